// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared types and arithmetic for the FIR MAC sequencer.
//   fir_state_t   : sequencer FSM states (IDLE, ISSUE, WAIT, OUTPUT)
//   DATA_W, ACC_W : sample/coefficient width and accumulator width
//   round_shift() : round-half-up arithmetic right shift of the accumulator
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUTPUT
    } fir_state_t;

    // One extra bit of headroom so adding the rounding constant to a
    // positive full-scale accumulator cannot flip the sign.
    function automatic logic signed [ACC_W:0] round_shift(
        input logic signed [ACC_W-1:0] acc,
        input int                      shift
    );
        logic signed [ACC_W:0] sum;
        sum = {acc[ACC_W-1], acc} + ((ACC_W + 1)'(1) << (shift - 1));
        return sum >>> shift;
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer_if
// Bundles the sample stream, coefficient write port and MAC16 operand bus.
//   in_valid/in_ready/in_sample              : input sample handshake
//   out_valid/out_ready/out_sample/out_sat   : output sample handshake
//   coef_we/coef_addr/coef_data              : coefficient write port
//   mac_a/mac_b/mac_c/mac_result             : MAC16 (A*B+C) operand/result bus
//   busy                                     : sequencer not idle
// Modports: master = environment side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface fir_mac_sequencer_if
    import fir_pkg::*;
#(
    parameter int TAPS = 16
);
    localparam int AW = $clog2(TAPS);

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_sample;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_sample;
    logic                     out_sat;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [DATA_W-1:0] coef_data;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [ACC_W-1:0]  mac_c;
    logic signed [ACC_W-1:0]  mac_result;
    logic                     busy;

    modport master (
        output in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data, mac_result,
        input  in_ready, out_valid, out_sample, out_sat, mac_a, mac_b, mac_c, busy
    );

    modport slave (
        input  in_valid, in_sample, out_ready, coef_we, coef_addr, coef_data, mac_result,
        output in_ready, out_valid, out_sample, out_sat, mac_a, mac_b, mac_c, busy
    );

endinterface

// File: rtl/fir_round_sat.sv
// ---------------------------------------------------------------------------
// fir_round_sat
// Combinational conversion of the final 32-bit accumulator to one sample.
//   acc        in  : signed accumulator
//   out_sample out : rounded, shifted sample (clamped or wrapped)
//   out_sat    out : clamping occurred
// Build option FIR_SAT_EN: clamp to the 16-bit signed range and flag it;
// otherwise keep the low 16 bits and tie out_sat to 0.
// ---------------------------------------------------------------------------
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     out_sat
);

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W + 1)'(32767);
    localparam logic signed [ACC_W:0] Y_MIN = -(ACC_W + 1)'(32768);

    logic signed [ACC_W:0] y;

    // Clamp the full-width rounded value into the output range.
    always_comb begin
        y          = round_shift(acc, SHIFT);
        out_sat    = 1'b0;
        out_sample = y[DATA_W-1:0];
        if (y > Y_MAX) begin
            out_sample = 16'sd32767;
            out_sat    = 1'b1;
        end else if (y < Y_MIN) begin
            out_sample = -16'sd32768;
            out_sat    = 1'b1;
        end
    end
`else
    assign out_sample = DATA_W'(round_shift(acc, SHIFT));
    assign out_sat    = 1'b0;
`endif

endmodule

// File: rtl/fir_mac_sequencer.sv
// ---------------------------------------------------------------------------
// fir_mac_sequencer
// Direct-form FIR sequencer feeding an external MAC16 (A*B+C) datapath.
// One tap per ISSUE/WAIT pair; the MAC result is folded back as the next addend.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : fir_mac_sequencer_if.slave (sample in/out, coefficient port,
//                MAC operand/result bus, busy)
// Build option FIR_SAT_EN (inside fir_round_sat): saturating output.
// ---------------------------------------------------------------------------
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS    = 16,
    parameter int MAC_LAT = 1,
    parameter int SHIFT   = 15
) (
    input logic                clk,
    input logic                rst_n,
    fir_mac_sequencer_if.slave bus
);

    localparam int            AW        = $clog2(TAPS);
    localparam int            WW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW-1:0] LAST_TAP  = AW'(TAPS - 1);
    localparam logic [WW-1:0] LAST_WAIT = WW'(MAC_LAT - 1);

    fir_state_t               state_q, state_d;
    logic signed [DATA_W-1:0] hist_q [TAPS];
    logic signed [DATA_W-1:0] hist_d [TAPS];
    logic signed [DATA_W-1:0] coef_q [TAPS];
    logic signed [DATA_W-1:0] coef_d [TAPS];
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            wptr_q, wptr_d;
    logic [AW-1:0]            k_q, k_d;
    logic [WW-1:0]            wcnt_q, wcnt_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
    logic                     out_sat_q, out_sat_d;
    logic                     busy_q, busy_d;
    logic signed [DATA_W-1:0] mac_a_q, mac_a_d;
    logic signed [DATA_W-1:0] mac_b_q, mac_b_d;
    logic signed [ACC_W-1:0]  mac_c_q, mac_c_d;
    logic signed [DATA_W-1:0] rs_sample;
    logic                     rs_sat;

    // The final sum is the last MAC result, so round it as it arrives and
    // register the output on the same edge that enters OUTPUT.
    fir_round_sat #(.SHIFT(SHIFT)) u_round_sat (
        .acc        (bus.mac_result),
        .out_sample (rs_sample),
        .out_sat    (rs_sat)
    );

    // Next-state logic. MAC operands are registered on the edge that enters
    // ISSUE so they are already stable during the ISSUE cycle; the first tap
    // bypasses the sample and a same-cycle coefficient write.
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        coef_d       = coef_q;
        acc_d        = acc_q;
        wptr_d       = wptr_q;
        k_d          = k_q;
        wcnt_d       = wcnt_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_sample_d = out_sample_q;
        out_sat_d    = out_sat_q;
        busy_d       = busy_q;
        mac_a_d      = mac_a_q;
        mac_b_d      = mac_b_q;
        mac_c_d      = mac_c_q;
        case (state_q)
            IDLE: begin
                if (bus.coef_we) begin
                    coef_d[bus.coef_addr] = bus.coef_data;
                end
                if (bus.in_valid) begin
                    hist_d[wptr_q] = bus.in_sample;
                    acc_d          = '0;
                    k_d            = '0;
                    mac_a_d        = bus.in_sample;
                    mac_b_d        = coef_d[0];
                    mac_c_d        = '0;
                    in_ready_d     = 1'b0;
                    busy_d         = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (wcnt_q == LAST_WAIT) begin
                    acc_d = bus.mac_result;
                    k_d   = k_q + AW'(1);
                    if (k_q == LAST_TAP) begin
                        out_valid_d  = 1'b1;
                        out_sample_d = rs_sample;
                        out_sat_d    = rs_sat;
                        state_d      = OUTPUT;
                    end else begin
                        mac_a_d = hist_q[wptr_q - (k_q + AW'(1))];
                        mac_b_d = coef_q[k_q + AW'(1)];
                        mac_c_d = bus.mac_result;
                        state_d = ISSUE;
                    end
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    wptr_d      = wptr_q + AW'(1);
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset also aborts any sample in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hist_q       <= '{default: '0};
            coef_q       <= '{default: '0};
            acc_q        <= '0;
            wptr_q       <= '0;
            k_q          <= '0;
            wcnt_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            out_sat_q    <= 1'b0;
            busy_q       <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            mac_c_q      <= '0;
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            coef_q       <= coef_d;
            acc_q        <= acc_d;
            wptr_q       <= wptr_d;
            k_q          <= k_d;
            wcnt_q       <= wcnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            out_sat_q    <= out_sat_d;
            busy_q       <= busy_d;
            mac_a_q      <= mac_a_d;
            mac_b_q      <= mac_b_d;
            mac_c_q      <= mac_c_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sample = out_sample_q;
    assign bus.out_sat    = out_sat_q;
    assign bus.busy       = busy_q;
    assign bus.mac_a      = mac_a_q;
    assign bus.mac_b      = mac_b_q;
    assign bus.mac_c      = mac_c_q;

endmodule
